// File: rtl/scan_chain_driver.sv
// Scan chain driver: each frame loads the selected design's input byte into its
// chain slot, latches, captures all design outputs and unloads the selected byte.
module scan_chain_driver #(
   parameter int unsigned NUM_DESIGNS = 100,
   parameter int unsigned SEL_W       = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [SEL_W-1:0] active_select,
   input  logic [7:0]       inputs,
   output logic [7:0]       outputs,
   output logic             ready,
   output logic             scan_clk,
   output logic             scan_data_out,
   input  logic             scan_data_in,
   output logic             scan_select,
   output logic             scan_latch_en
);

   localparam int unsigned L  = NUM_DESIGNS * 8;
   localparam int unsigned CW = $clog2(2 * L + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(2 * L - 1);
   localparam logic [CW-1:0] LAST_PAIR  = CW'(1);

   typedef enum logic [2:0] {
      ST_START,
      ST_LOAD,
      ST_LATCH,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [7:0]       din_q, din_d;
   logic [7:0]       shadow_q, shadow_d;
   logic [7:0]       outputs_q, outputs_d;
   logic             ready_q, ready_d;
   logic             scan_clk_q, scan_clk_d;
   logic             scan_data_out_q, scan_data_out_d;
   logic             scan_select_q, scan_select_d;
   logic             scan_latch_en_q, scan_latch_en_d;
   logic [CW-2:0]    k_q, k_d;
   logic [2:0]       bidx_q, bidx_d;

   // Shift k touches chain position L-1-k, i.e. design NUM_DESIGNS-1-k/8.
   function automatic logic slot_hit(input logic [CW-2:0] k, input logic [SEL_W-1:0] sel);
      int unsigned kk;
      kk = 32'(k);
      return ((NUM_DESIGNS - 1) - kk / 8) == 32'(sel);
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      din_d     = din_q;
      shadow_d  = shadow_q;
      outputs_d = outputs_q;
      k_q       = cnt_q[CW-1:1];
      bidx_q    = ~k_q[2:0];

      unique case (state_q)
         ST_START: begin
            sel_d    = active_select;
            din_d    = inputs;
            shadow_d = '0;
            cnt_d    = '0;
            state_d  = ST_LOAD;
         end
         ST_LOAD: begin
            if (cnt_q == LAST_SHIFT) begin
               cnt_d   = '0;
               state_d = ST_LATCH;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_LATCH: begin
            if (cnt_q == LAST_PAIR) begin
               cnt_d   = '0;
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_CAPTURE: begin
            if (cnt_q == LAST_PAIR) begin
               cnt_d   = '0;
               state_d = ST_UNLOAD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_UNLOAD: begin
            // scan_clk is low in phase 0, so the chain tail is stable at this edge.
            if (!cnt_q[0] && slot_hit(k_q, sel_q)) begin
               shadow_d[bidx_q] = scan_data_in;
            end
            if (cnt_q == LAST_SHIFT) begin
               cnt_d     = '0;
               outputs_d = shadow_q;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_START;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_START;
         end
      endcase

      // Pin values are decoded from the next state so they register alongside it.
      k_d             = cnt_d[CW-1:1];
      bidx_d          = ~k_d[2:0];
      ready_d         = (state_d == ST_DONE);
      scan_clk_d      = (((state_d == ST_LOAD) || (state_d == ST_UNLOAD)) && cnt_d[0]) ||
                        ((state_d == ST_CAPTURE) && (cnt_d == LAST_PAIR));
      scan_data_out_d = (state_d == ST_LOAD) && slot_hit(k_d, sel_d) && din_d[bidx_d];
      scan_select_d   = (state_d == ST_CAPTURE);
      scan_latch_en_d = (state_d == ST_LATCH) && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= ST_START;
         cnt_q           <= '0;
         sel_q           <= '0;
         din_q           <= '0;
         shadow_q        <= '0;
         outputs_q       <= '0;
         ready_q         <= 1'b0;
         scan_clk_q      <= 1'b0;
         scan_data_out_q <= 1'b0;
         scan_select_q   <= 1'b0;
         scan_latch_en_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         sel_q           <= sel_d;
         din_q           <= din_d;
         shadow_q        <= shadow_d;
         outputs_q       <= outputs_d;
         ready_q         <= ready_d;
         scan_clk_q      <= scan_clk_d;
         scan_data_out_q <= scan_data_out_d;
         scan_select_q   <= scan_select_d;
         scan_latch_en_q <= scan_latch_en_d;
      end
   end

   assign outputs       = outputs_q;
   assign ready         = ready_q;
   assign scan_clk      = scan_clk_q;
   assign scan_data_out = scan_data_out_q;
   assign scan_select   = scan_select_q;
   assign scan_latch_en = scan_latch_en_q;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: 4-stage behavioural chain whose designs output
// their latched input XOR 8'hFF; frames checked against rule-based expectations.
module tb_scan_chain_driver;

   localparam int NUM   = 4;
   localparam int SEL_W = 9;
   localparam int L     = NUM * 8;
   localparam int FRAME = 4 * L + 6;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [SEL_W-1:0] active_select = '0;
   logic [7:0]       inputs = '0;
   logic [7:0]       outputs;
   logic             ready;
   logic             scan_clk;
   logic             scan_data_out;
   logic             sdi;
   logic             scan_select;
   logic             scan_latch_en;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   scan_chain_driver #(
      .NUM_DESIGNS(NUM),
      .SEL_W      (SEL_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .active_select(active_select),
      .inputs       (inputs),
      .outputs      (outputs),
      .ready        (ready),
      .scan_clk     (scan_clk),
      .scan_data_out(scan_data_out),
      .scan_data_in (sdi),
      .scan_select  (scan_select),
      .scan_latch_en(scan_latch_en)
   );

   // Behavioural chain: position 0 is fed by the driver, position L-1 feeds back.
   logic       chain [L];
   logic [7:0] latched [NUM];
   logic       sclk_prev;

   initial begin
      for (int i = 0; i < L; i++) chain[i] = 1'($urandom_range(0, 1));
      for (int d = 0; d < NUM; d++) latched[d] = 8'($urandom);
      sclk_prev = 1'b0;
      sdi = chain[L-1];
   end

   always @(negedge clk) begin
      if (scan_clk && !sclk_prev) begin
         if (scan_select) begin
            for (int d = 0; d < NUM; d++)
               for (int b = 0; b < 8; b++)
                  chain[d*8+b] = ~latched[d][b];
         end else begin
            for (int i = L - 1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = scan_data_out;
         end
      end
      if (scan_latch_en) begin
         for (int d = 0; d < NUM; d++)
            for (int b = 0; b < 8; b++)
               latched[d][b] = chain[d*8+b];
      end
      sclk_prev = scan_clk;
      sdi = chain[L-1];
   end

   function automatic logic [7:0] exp_out(input logic [SEL_W-1:0] s, input logic [7:0] din);
      return (int'(s) < NUM) ? ~din : 8'h00;
   endfunction

   function automatic logic [7:0] exp_stage(input int d, input logic [SEL_W-1:0] s,
                                            input logic [7:0] din);
      return (int'(s) == d) ? din : 8'h00;
   endfunction

   int fr_cycles, fr_shift, fr_cap, fr_latch, fr_sel, fr_out_changes;

   // Runs until the next ready pulse (bounded), recording per-frame observations.
   task automatic run_frame(input int chg_at, input logic [SEL_W-1:0] chg_sel,
                            input logic [7:0] chg_din);
      logic       prev_clk;
      logic [7:0] prev_out;
      prev_clk = 1'b0;
      prev_out = outputs;
      fr_cycles = 0; fr_shift = 0; fr_cap = 0; fr_latch = 0; fr_sel = 0; fr_out_changes = 0;
      while (1) begin
         @(negedge clk);
         fr_cycles++;
         if (chg_at != 0 && fr_cycles == chg_at) begin
            active_select = chg_sel;
            inputs = chg_din;
         end
         if (scan_clk && !prev_clk) begin
            if (scan_select) fr_cap++;
            else fr_shift++;
         end
         prev_clk = scan_clk;
         if (scan_latch_en) fr_latch++;
         if (scan_select) fr_sel++;
         if (!ready && outputs !== prev_out) fr_out_changes++;
         prev_out = outputs;
         if (ready === 1'b1) break;
         if (fr_cycles >= 400) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      active_select = '0;
      inputs = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, expected 00", outputs);
      end
      vectors++;
      if ({ready, scan_clk, scan_data_out, scan_select, scan_latch_en} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_controls: got %b, expected 00000",
                  {ready, scan_clk, scan_data_out, scan_select, scan_latch_en});
      end
      active_select = 9'd2;
      inputs = 8'h35;
      reset_n = 1'b1;
   endtask

   task automatic test_first_frame();
      run_frame(0, '0, '0);
      vectors++;
      if (fr_cycles + 1 !== FRAME) begin
         miscompares++;
         $display("FAIL first_frame_len: got %0d, expected %0d", fr_cycles + 1, FRAME);
      end
      vectors++;
      if (outputs !== 8'hCA) begin
         miscompares++;
         $display("FAIL first_frame_out: got %h, expected CA", outputs);
      end
      for (int d = 0; d < NUM; d++) begin
         vectors++;
         if (latched[d] !== exp_stage(d, 9'd2, 8'h35)) begin
            miscompares++;
            $display("FAIL first_frame_stage%0d: got %h, expected %h", d, latched[d],
                     exp_stage(d, 9'd2, 8'h35));
         end
      end
   endtask

   task automatic test_back_to_back();
      active_select = 9'd0;
      inputs = 8'h01;
      run_frame(0, '0, '0);
      vectors++;
      if (fr_cycles !== FRAME || outputs !== 8'hFE) begin
         miscompares++;
         $display("FAIL b2b_sel0: got period %0d out %h, expected period %0d out FE",
                  fr_cycles, outputs, FRAME);
      end
      active_select = 9'd3;
      inputs = 8'h80;
      run_frame(0, '0, '0);
      vectors++;
      if (fr_cycles !== FRAME || outputs !== 8'h7F) begin
         miscompares++;
         $display("FAIL b2b_sel3: got period %0d out %h, expected period %0d out 7F",
                  fr_cycles, outputs, FRAME);
      end
   endtask

   task automatic test_out_of_range();
      active_select = 9'd5;
      inputs = 8'($urandom_range(1, 255));
      run_frame(0, '0, '0);
      vectors++;
      if (fr_cycles !== FRAME || outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL oor_frame: got period %0d out %h, expected period %0d out 00",
                  fr_cycles, outputs, FRAME);
      end
      for (int d = 0; d < NUM; d++) begin
         vectors++;
         if (latched[d] !== 8'h00) begin
            miscompares++;
            $display("FAIL oor_stage%0d: got %h, expected 00", d, latched[d]);
         end
      end
   endtask

   task automatic test_mid_frame_change();
      logic [SEL_W-1:0] s, s2;
      s  = SEL_W'($urandom_range(0, NUM - 1));
      s2 = SEL_W'((int'(s) + 1) % NUM);
      active_select = s;
      inputs = 8'hAA;
      run_frame(30, s2, 8'h55);
      vectors++;
      if (outputs !== exp_out(s, 8'hAA)) begin
         miscompares++;
         $display("FAIL midchg_first: got %h, expected %h", outputs, exp_out(s, 8'hAA));
      end
      vectors++;
      if (latched[s] !== 8'hAA) begin
         miscompares++;
         $display("FAIL midchg_stage: got %h, expected AA", latched[s]);
      end
      run_frame(0, '0, '0);
      vectors++;
      if (outputs !== exp_out(s2, 8'h55)) begin
         miscompares++;
         $display("FAIL midchg_second: got %h, expected %h", outputs, exp_out(s2, 8'h55));
      end
   endtask

   task automatic test_protocol();
      logic [SEL_W-1:0] s;
      logic [7:0]       din;
      s   = SEL_W'($urandom_range(0, NUM - 1));
      din = 8'($urandom_range(0, 254));
      active_select = s;
      inputs = din;
      run_frame(0, '0, '0);
      vectors++;
      if (fr_shift !== 2 * L) begin
         miscompares++;
         $display("FAIL proto_shift_rises: got %0d, expected %0d", fr_shift, 2 * L);
      end
      vectors++;
      if (fr_cap !== 1) begin
         miscompares++;
         $display("FAIL proto_capture_rises: got %0d, expected 1", fr_cap);
      end
      vectors++;
      if (fr_latch !== 1) begin
         miscompares++;
         $display("FAIL proto_latch_cycles: got %0d, expected 1", fr_latch);
      end
      vectors++;
      if (fr_sel !== 2) begin
         miscompares++;
         $display("FAIL proto_select_cycles: got %0d, expected 2", fr_sel);
      end
      vectors++;
      if (fr_out_changes !== 0 || outputs !== exp_out(s, din)) begin
         miscompares++;
         $display("FAIL proto_out: got %h with %0d mid-frame changes, expected %h with 0",
                  outputs, fr_out_changes, exp_out(s, din));
      end
   endtask

   task automatic test_reset_mid_unload();
      int ready_seen;
      ready_seen = 0;
      active_select = 9'd1;
      inputs = 8'h3C;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready === 1'b1) ready_seen++;
      end
      reset_n = 1'b0;
      @(negedge clk);
      if (ready === 1'b1) ready_seen++;
      vectors++;
      if (ready_seen !== 0) begin
         miscompares++;
         $display("FAIL abort_ready: got %0d pulses, expected 0", ready_seen);
      end
      vectors++;
      if (outputs !== 8'h00) begin
         miscompares++;
         $display("FAIL abort_outputs: got %h, expected 00", outputs);
      end
      reset_n = 1'b1;
      run_frame(0, '0, '0);
      vectors++;
      if (fr_cycles + 1 !== FRAME || outputs !== 8'hC3) begin
         miscompares++;
         $display("FAIL abort_fresh_frame: got len %0d out %h, expected len %0d out C3",
                  fr_cycles + 1, outputs, FRAME);
      end
   endtask

   task automatic test_random();
      logic [SEL_W-1:0] s;
      logic [7:0]       din;
      for (int f = 0; f < 8; f++) begin
         s   = SEL_W'($urandom_range(0, NUM + 1));
         din = 8'($urandom);
         active_select = s;
         inputs = din;
         run_frame(0, '0, '0);
         vectors++;
         if (fr_cycles !== FRAME || fr_out_changes !== 0 || outputs !== exp_out(s, din)) begin
            miscompares++;
            $display("FAIL rand%0d_out: got period %0d changes %0d out %h, expected %0d 0 %h",
                     f, fr_cycles, fr_out_changes, outputs, FRAME, exp_out(s, din));
         end
         for (int d = 0; d < NUM; d++) begin
            vectors++;
            if (latched[d] !== exp_stage(d, s, din)) begin
               miscompares++;
               $display("FAIL rand%0d_stage%0d: got %h, expected %h", f, d, latched[d],
                        exp_stage(d, s, din));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_back_to_back();
      test_out_of_range();
      test_mid_frame_change();
      test_protocol();
      test_reset_mid_unload();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
